// File: rtl/adsr_envelope_pkg.sv
// Shared definitions for the ADSR envelope block: stage encoding seen on the stage output.
package adsr_envelope_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_e;
endpackage

// File: rtl/adsr_envelope_lrclk_tick.sv
// Two-flop synchroniser for an asynchronous strobe plus a one-clock pulse on its rising edge.
module lrclk_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);
  // [1:0] synchronise, [2] holds the previous synchronised level for edge detection
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: one level update per lrclk sample tick, gain on out feeds the multiplier.
module adsr_envelope
  import adsr_envelope_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int RATESIZE = 16,
  parameter int FRAC     = 8
) (
  input  logic                bclk,
  input  logic                reset,
  input  logic                lrclk,
  input  logic                gate,
  input  logic [RATESIZE-1:0] attack_step,
  input  logic [RATESIZE-1:0] decay_step,
  input  logic [RATESIZE-1:0] release_step,
  input  logic [BITSIZE-2:0]  sustain_level,
  output logic [BITSIZE-1:0]  out,
  output logic                active,
  output logic [2:0]          stage
);
  localparam int LW = BITSIZE - 1 + FRAC;
  localparam logic [LW-1:0] LMAX = '1;

  logic          tick;
  logic [1:0]    gate_q;
  logic          gate_s;
  stage_e        stage_q, stage_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] sus;
  // One guard bit on every operand so sums/differences never wrap
  logic [LW:0]   lvl_x, sus_x, a_x, d_x, r_x, sum, dec_diff, rel_diff;

  lrclk_tick u_tick (
    .clk_i  (bclk),
    .rst_i  (reset),
    .async_i(lrclk),
    .rise_o (tick)
  );

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) gate_q <= '0;
    else       gate_q <= {gate_q[0], gate};
  end
  assign gate_s = gate_q[1];

  assign sus      = {sustain_level, {FRAC{1'b0}}};
  assign lvl_x    = {1'b0, lvl_q};
  assign sus_x    = {1'b0, sus};
  assign a_x      = (LW+1)'(attack_step);
  assign d_x      = (LW+1)'(decay_step);
  assign r_x      = (LW+1)'(release_step);
  assign sum      = lvl_x + a_x;
  assign dec_diff = lvl_x - d_x;
  assign rel_diff = lvl_x - r_x;

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      stage_q <= IDLE;
      lvl_q   <= '0;
    end else begin
      stage_q <= stage_d;
      lvl_q   <= lvl_d;
    end
  end

  // Gate is examined before the step: a gate change on a tick moves stage only
  always_comb begin
    stage_d = stage_q;
    lvl_d   = lvl_q;
    if (tick) begin
      unique case (stage_q)
        IDLE: begin
          if (gate_s) stage_d = ATTACK;
        end
        ATTACK: begin
          if (!gate_s) stage_d = RELEASE;
          else if (sum >= {1'b0, LMAX} || attack_step == '0) begin
            lvl_d   = LMAX;
            stage_d = DECAY;
          end else lvl_d = sum[LW-1:0];
        end
        DECAY: begin
          if (!gate_s) stage_d = RELEASE;
          else if (dec_diff[LW] || dec_diff <= sus_x || decay_step == '0 || sus_x >= lvl_x) begin
            lvl_d   = sus;
            stage_d = SUSTAIN;
          end else lvl_d = dec_diff[LW-1:0];
        end
        SUSTAIN: begin
          if (!gate_s) stage_d = RELEASE;
          else         lvl_d   = sus;
        end
        RELEASE: begin
          if (gate_s) stage_d = ATTACK;
          else if (lvl_x <= r_x || release_step == '0) begin
            lvl_d   = '0;
            stage_d = IDLE;
          end else lvl_d = rel_diff[LW-1:0];
        end
        default: begin
          stage_d = IDLE;
          lvl_d   = '0;
        end
      endcase
    end
  end

  assign out    = {1'b0, lvl_q[LW-1:FRAC]};
  assign stage  = stage_q;
  assign active = (stage_q != IDLE);
endmodule
